// File: rtl/pwm_dac.sv
// 8-bit sample to 1-bit PWM output stage with a one-deep holding register.
// New samples are promoted to the active duty only at PWM period boundaries.
module pwm_dac #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       pwm_out,
    output logic       period_strobe,
    output logic       underrun
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    state_e         state_q, state_d;
    logic [PsW-1:0] psc_q, psc_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     duty_q, duty_d;
    logic [7:0]     pend_q, pend_d;
    logic           full_q, full_d;

    logic counting;
    logic tick;
    logic period_end;
    logic accept;

    assign counting     = (state_q != StIdle);
    assign tick         = counting && (psc_q == PsMax);
    assign period_end   = tick && (cnt_q == 8'hFF);
    assign accept       = sample_valid && !full_q;
    assign sample_ready = !full_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = StArm;
            StArm: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (period_end && full_q) begin
                    state_d = StRun;
                end
            end
            StRun:   if (!en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pwm_out       = (state_q == StRun) && (cnt_q < duty_q);
        period_strobe = period_end;
        underrun      = period_end && (state_q == StRun) && !full_q;
    end

    // Datapath: the period-end transfer only fires when full, and accept only when
    // empty, so the two never touch the holding register in the same cycle.
    always_comb begin
        psc_d  = psc_q;
        cnt_d  = cnt_q;
        duty_d = duty_q;
        pend_d = pend_q;
        full_d = full_q;
        if (!counting || !en) begin
            psc_d  = '0;
            cnt_d  = '0;
            duty_d = '0;
        end else begin
            if (tick) begin
                psc_d = '0;
                cnt_d = cnt_q + 8'd1;
            end else begin
                psc_d = psc_q + PsW'(1);
            end
            if (period_end && full_q) begin
                duty_d = pend_q;
                full_d = 1'b0;
            end
        end
        if (accept) begin
            pend_d = sample_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            psc_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
            pend_q <= '0;
            full_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pend_q <= pend_d;
            full_q <= full_d;
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: two instances (PRESCALE 1 and 4) checked every cycle against
// a time-based model of the period, duty and holding register.
module tb_pwm_dac;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [1:0] en_w;
    logic [1:0] vld_w;
    logic [7:0] smp_w [2];
    logic [1:0] rdy_w, pwm_w, stb_w, udr_w;

    pwm_dac #(.PRESCALE(1)) u_dut1 (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en_w[0]),
        .sample_in    (smp_w[0]),
        .sample_valid (vld_w[0]),
        .sample_ready (rdy_w[0]),
        .pwm_out      (pwm_w[0]),
        .period_strobe(stb_w[0]),
        .underrun     (udr_w[0])
    );

    pwm_dac #(.PRESCALE(4)) u_dut4 (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en_w[1]),
        .sample_in    (smp_w[1]),
        .sample_valid (vld_w[1]),
        .sample_ready (rdy_w[1]),
        .pwm_out      (pwm_w[1]),
        .period_strobe(stb_w[1]),
        .underrun     (udr_w[1])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: elapsed clocks in the current period, played = a sample has started.
    bit m_on [2], m_run [2], m_full [2];
    int m_el [2], m_duty [2], m_pend [2];

    // Stimulus control.
    bit en_r [2], rnd [2], gaps [2], acc_r [2], from_q [2];
    int feed [2];
    int q0 [$];
    int q1 [$];
    int hi_cnt [2], gap_cnt [2];
    bit seen [2];

    function automatic int ps_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_on[i] = 0; m_run[i] = 0; m_full[i] = 0;
            m_el[i] = 0; m_duty[i] = 0; m_pend[i] = 0;
            hi_cnt[i] = 0; gap_cnt[i] = 0; seen[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            int  val;
            bit  have;
            have = 0;
            val  = 0;
            from_q[i] = 0;
            if (i == 0 && q0.size() > 0) begin
                have = 1; val = q0[0]; from_q[i] = 1;
            end else if (i == 1 && q1.size() > 0) begin
                have = 1; val = q1[0]; from_q[i] = 1;
            end else if (feed[i] >= 0) begin
                have = 1; val = feed[i];
            end
            en_w[i]  = en_r[i];
            vld_w[i] = have && (!gaps[i] || $urandom_range(2) != 0);
            smp_w[i] = have ? 8'(val) : 8'($urandom_range(255));
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) begin
            int p, ps, pos;
            bit pe, exp_pwm;
            ps      = ps_of(i);
            p       = 256 * ps;
            pos     = m_el[i] % p;
            pe      = m_on[i] && (pos == p - 1);
            exp_pwm = m_on[i] && m_run[i] && ((pos / ps) < m_duty[i]);
            check($sformatf("pwm[%0d]", i), pwm_w[i], exp_pwm);
            check($sformatf("ready[%0d]", i), rdy_w[i], !m_full[i]);
            check($sformatf("strobe[%0d]", i), stb_w[i], pe);
            check($sformatf("underrun[%0d]", i), udr_w[i], pe && m_run[i] && !m_full[i]);
            if (m_on[i]) begin
                if (pwm_w[i] === 1'b1) hi_cnt[i]++;
                gap_cnt[i]++;
                if (stb_w[i] === 1'b1) begin
                    check($sformatf("hicnt[%0d]", i), hi_cnt[i], m_run[i] ? m_duty[i] * ps : 0);
                    if (seen[i]) check($sformatf("period[%0d]", i), gap_cnt[i], p);
                    seen[i] = 1; hi_cnt[i] = 0; gap_cnt[i] = 0;
                end
            end else begin
                hi_cnt[i] = 0; gap_cnt[i] = 0; seen[i] = 0;
            end
            acc_r[i] = vld_w[i] && !m_full[i];
            if (n_rst) begin
                if (!m_on[i]) begin
                    if (en_w[i]) begin m_on[i] = 1; m_run[i] = 0; m_el[i] = 0; end
                end else if (!en_w[i]) begin
                    m_on[i] = 0; m_run[i] = 0; m_el[i] = 0; m_duty[i] = 0;
                end else begin
                    if (pe && m_full[i]) begin
                        m_duty[i] = m_pend[i]; m_full[i] = 0; m_run[i] = 1;
                    end
                    m_el[i] = (m_el[i] + 1) % p;
                end
                if (acc_r[i]) begin m_pend[i] = smp_w[i]; m_full[i] = 1; end
            end else begin
                acc_r[i] = 0;
            end
        end
        if (!n_rst) model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_r[i]) begin
                if (from_q[i] && i == 0) void'(q0.pop_front());
                else if (from_q[i] && i == 1) void'(q1.pop_front());
                else if (rnd[i]) feed[i] = $urandom_range(255);
            end
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic mid_reset();
        #3;
        n_rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_pwm[%0d]", i), pwm_w[i], 0);
            check($sformatf("rst_strobe[%0d]", i), stb_w[i], 0);
            check($sformatf("rst_underrun[%0d]", i), udr_w[i], 0);
            check($sformatf("rst_ready[%0d]", i), rdy_w[i], 1);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en_r[i] = 0; rnd[i] = 0; gaps[i] = 0; feed[i] = -1;
        end
        model_reset();
        drive();
        #1;
        run(3);
        n_rst = 1'b1;

        // Load while idle: ready drops, output stays silent.
        feed[0] = 77;
        drive();
        run(6);
        feed[0] = -1;

        // Steady duty 64 after the arming period.
        en_r[0] = 1;
        feed[0] = 64;
        drive();
        run(256 * 5);

        // Extremes then 128, then starve to force underrun, then recover with 32.
        q0.push_back(0);
        q0.push_back(255);
        q0.push_back(1);
        feed[0] = 128;
        run(256 * 6);
        feed[0] = -1;
        run(256 * 3);
        feed[0] = 32;
        run(256 * 2);

        // Back-to-back samples held under backpressure.
        feed[0] = -1;
        q0.push_back(10);
        q0.push_back(20);
        run(256 * 4);

        // Randomized samples with valid gaps and an enable drop mid-period.
        rnd[0]  = 1;
        gaps[0] = 1;
        feed[0] = $urandom_range(255);
        run(256 * 4 + $urandom_range(50, 200));
        en_r[0] = 0;
        drive();
        run(5);
        en_r[0] = 1;
        drive();
        run(256 * 3 + $urandom_range(10, 200));

        // Asynchronous reset in the middle of a period.
        mid_reset();
        run(300);

        en_r[0] = 0;
        feed[0] = -1;
        rnd[0]  = 0;
        gaps[0] = 0;
        drive();

        // PRESCALE=4: duty 100, drop enable mid-period, re-enable with pending sample.
        feed[1] = 100;
        en_r[1] = 1;
        drive();
        run(1024 * 3 + 300);
        en_r[1] = 0;
        drive();
        run(5);
        feed[1] = -1;
        q1.push_back(150);
        en_r[1] = 1;
        drive();
        run(1024 * 3 + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
